// File: rtl/reg_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reg_file_pkg                                           |
// | Description : Shared defaults and reset-value helper for reg_file_sb |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package reg_file_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_NUM_RD     = 2;

  // Wide return so the caller truncates to whatever word width it uses.
  function automatic logic [63:0] reset_value(input int unsigned idx);
    return 64'(idx);
  endfunction

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reg_scoreboard                                         |
// | Description : Per-register busy tracking, WAW stall, busy count and  |
// |               sticky unexpected-writeback flag. Optional read bypass |
// |               of busy flags under REG_FILE_BYPASS_EN.                |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_en,
  input  logic [$clog2(DEPTH)-1:0]        issue_dest,
  input  logic                            wb_en,
  input  logic [$clog2(DEPTH)-1:0]        wb_dest,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] lk_addr,
  output logic [NUM_RD-1:0]               lk_busy,
  output logic                            stall,
  output logic [$clog2(DEPTH):0]          busy_cnt,
  output logic                            wb_unexp
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [CNT_W-1:0] r_busy_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_wb_unexp;
  logic             w_wb_same;
  logic             w_issue_acc;

  // A writeback retiring the same index frees the slot for the new owner.
  assign w_wb_same   = wb_en && (wb_dest == issue_dest);
  assign stall       = issue_en && r_busy[issue_dest] && !w_wb_same;
  assign w_issue_acc = issue_en && !stall;

  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) begin
      w_busy_nxt[wb_dest] = 1'b0;
    end
    if (w_issue_acc) begin
      w_busy_nxt[issue_dest] = 1'b1;
    end
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_wb_unexp <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
      if (wb_en && !r_busy[wb_dest]) begin
        r_wb_unexp <= 1'b1;
      end
    end
  end

  assign busy_cnt = r_busy_cnt;
  assign wb_unexp = r_wb_unexp;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lk
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = lk_addr[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
    assign lk_busy[k] = (wb_en && (wb_dest == w_addr))
                        ? (w_issue_acc && (issue_dest == w_addr))
                        : r_busy[w_addr];
`else
    assign lk_busy[k] = r_busy[w_addr];
`endif
  end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reg_file_sb                                            |
// | Description : Parametrised register file with busy scoreboard and    |
// |               multiple read ports. Define REG_FILE_BYPASS_EN to      |
// |               forward same-cycle writeback data to the read ports.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_RD     = DEF_NUM_RD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr,
  output logic [NUM_RD*WORD_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic                            issue_en,
  input  logic [$clog2(DEPTH)-1:0]        issue_dest,
  output logic                            stall,
  input  logic                            wb_en,
  input  logic [$clog2(DEPTH)-1:0]        wb_dest,
  input  logic [WORD_WIDTH-1:0]           wb_data,
  output logic [$clog2(DEPTH):0]          busy_cnt,
  output logic                            wb_unexp
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= WORD_WIDTH'(reset_value(i));
      end
    end else if (wb_en) begin
      r_mem[wb_dest] <= wb_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
    assign rd_data[k*WORD_WIDTH +: WORD_WIDTH] =
      (wb_en && (wb_dest == w_addr)) ? wb_data : r_mem[w_addr];
`else
    assign rd_data[k*WORD_WIDTH +: WORD_WIDTH] = r_mem[w_addr];
`endif
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .lk_addr    (rd_addr),
    .lk_busy    (rd_busy),
    .stall      (stall),
    .busy_cnt   (busy_cnt),
    .wb_unexp   (wb_unexp)
  );

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_reg_file_sb                                         |
// | Description : Directed self-checking bench for reg_file_sb           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_reg_file_sb;

`ifdef REG_FILE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        stall;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic [4:0]  busy_cnt;
  logic        wb_unexp;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_sb #(.WORD_WIDTH(32), .DEPTH(16), .NUM_RD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .stall      (stall),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .busy_cnt   (busy_cnt),
    .wb_unexp   (wb_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; issue_dest = '0;
    wb_en = 1'b0; wb_dest = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); rd_addr = '0;
    repeat (3) tick();
    n_cmp++;
    if (busy_cnt !== 5'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
    n_cmp++;
    if (wb_unexp !== 1'b0) begin n_err++; $display("FAIL reset_unexp got %b want 0", wb_unexp); end
    #2 rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      rd_addr = {4'(15 - i), 4'(i)};
      #1;
      n_cmp++;
      if (rd_data[31:0] !== 32'(i)) begin n_err++; $display("FAIL reset_rd0[%0d] got %h want %h", i, rd_data[31:0], 32'(i)); end
      n_cmp++;
      if (rd_data[63:32] !== 32'(15 - i)) begin n_err++; $display("FAIL reset_rd1[%0d] got %h want %h", i, rd_data[63:32], 32'(15 - i)); end
      n_cmp++;
      if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy[%0d] got %b want 00", i, rd_busy); end
    end
    n_cmp++;
    if (busy_cnt !== 5'd0) begin n_err++; $display("FAIL reset_cnt_after got %0d want 0", busy_cnt); end
  endtask

  task automatic test_stall();
    tick();
    idle(); rd_addr = {4'd0, 4'd5};
    issue_en = 1'b1; issue_dest = 4'd5;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL stall_first got %b want 0", stall); end
    tick();
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL stall_second got %b want 1", stall); end
    n_cmp++;
    if (busy_cnt !== 5'd1) begin n_err++; $display("FAIL stall_cnt1 got %0d want 1", busy_cnt); end
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL stall_busy5 got %b want 1", rd_busy[0]); end
    tick();
    n_cmp++;
    if (busy_cnt !== 5'd1) begin n_err++; $display("FAIL stall_cnt_hold got %0d want 1", busy_cnt); end
    idle(); wb_en = 1'b1; wb_dest = 4'd5; wb_data = 32'hDEAD;
    tick();
    idle();
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd0) begin n_err++; $display("FAIL wb5_cnt got %0d want 0", busy_cnt); end
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEAD) begin n_err++; $display("FAIL wb5_data got %h want 0000dead", rd_data[31:0]); end
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL wb5_busy got %b want 0", rd_busy[0]); end
    n_cmp++;
    if (wb_unexp !== 1'b0) begin n_err++; $display("FAIL wb5_unexp got %b want 0", wb_unexp); end
  endtask

  task automatic test_same_cycle();
    idle(); rd_addr = {4'd3, 4'd3};
    issue_en = 1'b1; issue_dest = 4'd3;
    tick();
    issue_en = 1'b1; issue_dest = 4'd3;
    wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'h1234;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL same_stall got %b want 0", stall); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h1234) begin n_err++; $display("FAIL same_data got %h want 00001234", rd_data[31:0]); end
    n_cmp++;
    if (rd_busy[1] !== 1'b1) begin n_err++; $display("FAIL same_busy got %b want 1", rd_busy[1]); end
    n_cmp++;
    if (busy_cnt !== 5'd1) begin n_err++; $display("FAIL same_cnt got %0d want 1", busy_cnt); end
    wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'h5678;
    tick();
    idle();
    n_cmp++;
    if (busy_cnt !== 5'd0) begin n_err++; $display("FAIL same_clr_cnt got %0d want 0", busy_cnt); end
    n_cmp++;
    if (wb_unexp !== 1'b0) begin n_err++; $display("FAIL same_unexp got %b want 0", wb_unexp); end
  endtask

  task automatic test_unexp();
    idle(); rd_addr = {4'd0, 4'd7};
    wb_en = 1'b1; wb_dest = 4'd7; wb_data = 32'h7777;
    tick();
    idle();
    #1;
    n_cmp++;
    if (wb_unexp !== 1'b1) begin n_err++; $display("FAIL unexp_set got %b want 1", wb_unexp); end
    n_cmp++;
    if (rd_data[31:0] !== 32'h7777) begin n_err++; $display("FAIL unexp_data got %h want 00007777", rd_data[31:0]); end
    repeat (3) tick();
    n_cmp++;
    if (wb_unexp !== 1'b1) begin n_err++; $display("FAIL unexp_sticky got %b want 1", wb_unexp); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (wb_unexp !== 1'b0) begin n_err++; $display("FAIL unexp_rst got %b want 0", wb_unexp); end
    n_cmp++;
    if (rd_data[31:0] !== 32'd7) begin n_err++; $display("FAIL unexp_rst_data got %h want 00000007", rd_data[31:0]); end
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    idle(); rd_addr = {4'd9, 4'd9};
    wb_en = 1'b1; wb_dest = 4'd9; wb_data = 32'hCAFE;
    #1;
    n_cmp++;
    if (rd_data[31:0] !== (c_byp ? 32'hCAFE : 32'd9)) begin n_err++; $display("FAIL byp_same got %h want %h", rd_data[31:0], (c_byp ? 32'hCAFE : 32'd9)); end
    n_cmp++;
    if (rd_busy !== 2'b00) begin n_err++; $display("FAIL byp_busy got %b want 00", rd_busy); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[63:32] !== 32'hCAFE) begin n_err++; $display("FAIL byp_next got %h want 0000cafe", rd_data[63:32]); end
    // Writeback plus accepted issue of the same index.
    issue_en = 1'b1; issue_dest = 4'd9;
    wb_en = 1'b1; wb_dest = 4'd9; wb_data = 32'hBEEF;
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0 && !c_byp) begin n_err++; $display("FAIL byp_iss_busy got %b want 0", rd_busy[0]); end
    else if (rd_busy[0] !== 1'b1 && c_byp) begin n_err++; $display("FAIL byp_iss_busy got %b want 1", rd_busy[0]); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL byp_iss_after got %b want 1", rd_busy[0]); end
  endtask

  task automatic test_back_to_back();
    idle(); rd_addr = {4'd4, 4'd4};
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      issue_en = 1'b1; issue_dest = 4'(i);
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall[%0d] got %b want 0", i, stall); end
      tick();
    end
    idle();
    n_cmp++;
    if (busy_cnt !== 5'd16) begin n_err++; $display("FAIL b2b_full got %0d want 16", busy_cnt); end
    wb_en = 1'b1; wb_dest = 4'd4; wb_data = 32'h4444;
    tick();
    idle();
    n_cmp++;
    if (busy_cnt !== 5'd15) begin n_err++; $display("FAIL b2b_one_wb got %0d want 15", busy_cnt); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd0) begin n_err++; $display("FAIL b2b_async_rst got %0d want 0", busy_cnt); end
    n_cmp++;
    if (rd_data[31:0] !== 32'd4) begin n_err++; $display("FAIL b2b_rst_data got %h want 00000004", rd_data[31:0]); end
    #2 rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_same_cycle();
    test_unexp();
    test_bypass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_file_sb
`default_nettype wire
